button_cond: RTL and testbench

BUTTON_COND -- requirements
Module: button_cond

---
 rtl/btn_pkg.sv | 17 +
 rtl/button_cond_if.sv | 28 ++
 rtl/debounce_fsm.sv | 103 ++++++++++
 rtl/button_cond.sv | 60 ++++++
 tb/tb_button_cond.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning block: debounce FSM state
// encoding and the default timing constants.
package btn_pkg;

    // One debounce FSM per button; level is asserted in StPressed/StCheckRelease.
    typedef enum logic [1:0] {
        StReleased     = 2'd0,
        StCheckPress   = 2'd1,
        StPressed      = 2'd2,
        StCheckRelease = 2'd3
    } btn_state_e;

    // 10 ms of stable input at a 100 MHz system clock.
    localparam int unsigned DefaultDebounceCycles = 1000000;
    localparam int unsigned DefaultSyncStages     = 2;

endpackage

// File: rtl/button_cond_if.sv
// Bundle of raw user inputs and conditioned outputs of button_cond.
// The board/stimulus side is the master; the conditioning block is the slave.
interface button_cond_if;

    logic       btnU;
    logic       btnL;
    logic       btnC;
    logic [7:0] sw;

    logic [7:0] sw_sync;
    logic       btnU_lvl;
    logic       btnL_lvl;
    logic       btnC_lvl;
    logic       loadA_pulse;
    logic       loadB_pulse;
    logic       clr_pulse;

    modport master (
        output btnU, btnL, btnC, sw,
        input  sw_sync, btnU_lvl, btnL_lvl, btnC_lvl, loadA_pulse, loadB_pulse, clr_pulse
    );

    modport slave (
        input  btnU, btnL, btnC, sw,
        output sw_sync, btnU_lvl, btnL_lvl, btnC_lvl, loadA_pulse, loadB_pulse, clr_pulse
    );

endinterface

// File: rtl/debounce_fsm.sv
// Conditions one raw push-button: synchronizer, 4-state debounce FSM with a
// saturating stability counter, debounced level and a single-cycle press strobe.
module debounce_fsm
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned SYNC_STAGES     = DefaultSyncStages
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic lvl_o,
    output logic pulse_o
);

    // One extra bit so the terminal count always fits without overflow.
    localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntTerm = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;

    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, pulse_d;

    // Metastability synchronizer; only the last stage is used by the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // State, counter and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReleased;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic; the counter only advances below the terminal count,
    // so it saturates instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (btn_sync) begin
                    state_d = StCheckPress;
                    cnt_d   = '0;
                end
            end
            StCheckPress: begin
                if (!btn_sync) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == CntTerm) begin
                    state_d = StPressed;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!btn_sync) begin
                    state_d = StCheckRelease;
                    cnt_d   = '0;
                end
            end
            StCheckRelease: begin
                if (btn_sync) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntTerm) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe is registered so it is glitch-free for use as a load enable.
    assign pulse_o = pulse_q;
    assign lvl_o   = (state_q == StPressed) || (state_q == StCheckRelease);

endmodule

// File: rtl/button_cond.sv
// Conditions the board's push-buttons and slide switches: debounced button
// levels, one-cycle press strobes for operand load/clear, synchronized switches.
module button_cond
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned SYNC_STAGES     = DefaultSyncStages
) (
    input  logic          clk,
    input  logic          rst,
    button_cond_if.slave  bus
);

    logic [SYNC_STAGES-1:0][7:0] sw_sync_q;

    // Switch synchronizer: pure delay line, no filtering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync_q <= '0;
        end else begin
            sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw};
        end
    end

    assign bus.sw_sync = sw_sync_q[SYNC_STAGES-1];

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_u (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btnU),
        .lvl_o   (bus.btnU_lvl),
        .pulse_o (bus.loadA_pulse)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_l (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btnL),
        .lvl_o   (bus.btnL_lvl),
        .pulse_o (bus.loadB_pulse)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn_c (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btnC),
        .lvl_o   (bus.btnC_lvl),
        .pulse_o (bus.clr_pulse)
    );

endmodule

// File: tb/tb_button_cond.sv
// Directed bench for button_cond with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_button_cond;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    button_cond_if bus ();

    button_cond #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Button vectors are ordered {C, L, U}.
    typedef struct {
        logic [2:0] btn;
        logic [7:0] sw;
        logic [2:0] exp_lvl;
        logic [2:0] exp_pulse;
        logic [7:0] exp_sw;
    } vec_t;

    localparam int NumVec = 30;
    vec_t vecs [NumVec];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] lvl_vec();
        return {bus.btnC_lvl, bus.btnL_lvl, bus.btnU_lvl};
    endfunction

    function automatic logic [2:0] pulse_vec();
        return {bus.clr_pulse, bus.loadB_pulse, bus.loadA_pulse};
    endfunction

    task automatic drive_btn(input logic [2:0] b);
        bus.btnU = b[0];
        bus.btnL = b[1];
        bus.btnC = b[2];
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Clean btnU press held 20 cycles, plus two switch changes.
        // Row k is checked at falling edge k, then its inputs are driven.
        for (int k = 0; k < NumVec; k++) begin
            vecs[k].btn       = (k < 20) ? 3'b001 : 3'b000;
            vecs[k].sw        = (k < 12) ? 8'h3C : 8'hC3;
            vecs[k].exp_lvl   = (k >= 7 && k <= 26) ? 3'b001 : 3'b000;
            vecs[k].exp_pulse = (k == 7) ? 3'b001 : 3'b000;
            vecs[k].exp_sw    = (k < 2) ? 8'h00 : ((k < 14) ? 8'h3C : 8'hC3);
        end

        rst = 1'b1;
        drive_btn(3'b000);
        bus.sw = 8'h00;
        repeat (3) step();
        check("reset_lvl", 8'(lvl_vec()), 8'h00);
        check("reset_pulse", 8'(pulse_vec()), 8'h00);
        check("reset_sw_sync", bus.sw_sync, 8'h00);
        rst = 1'b0;

        for (int k = 0; k < NumVec; k++) begin
            step();
            check($sformatf("vec%0d_lvl", k), 8'(lvl_vec()), 8'(vecs[k].exp_lvl));
            check($sformatf("vec%0d_pulse", k), 8'(pulse_vec()), 8'(vecs[k].exp_pulse));
            check($sformatf("vec%0d_sw_sync", k), bus.sw_sync, vecs[k].exp_sw);
            drive_btn(vecs[k].btn);
            bus.sw = vecs[k].sw;
        end
        repeat (4) step();

        // Bounce on btnL: 1,0,1,0 then held; single strobe 7 cycles after the hold.
        step();
        check("bounce_idle_lvl", 8'(bus.btnL_lvl), 8'h00);
        bus.btnL = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("bounce%0d_pulse", k), 8'(pulse_vec()), (k == 11) ? 8'h02 : 8'h00);
            check($sformatf("bounce%0d_lvl", k), 8'(bus.btnL_lvl), (k >= 11) ? 8'h01 : 8'h00);
            bus.btnL = (k == 1 || k == 3) ? 1'b0 : 1'b1;
        end
        bus.btnL = 1'b0;
        repeat (10) step();

        // Release bounce on btnC: short drop must not clear the level or re-strobe.
        step();
        bus.btnC = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("relb%0d_pulse", k), 8'(pulse_vec()), (k == 7) ? 8'h04 : 8'h00);
            check($sformatf("relb%0d_lvl", k), 8'(bus.btnC_lvl), (k >= 7) ? 8'h01 : 8'h00);
            bus.btnC = (k == 8 || k == 9) ? 1'b0 : 1'b1;
        end
        bus.btnC = 1'b0;
        repeat (10) step();
        check("relb_final_lvl", 8'(lvl_vec()), 8'h00);

        // Simultaneous press of all three buttons.
        step();
        drive_btn(3'b111);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("sim%0d_pulse", k), 8'(pulse_vec()), (k == 7) ? 8'h07 : 8'h00);
        end
        drive_btn(3'b000);
        repeat (12) step();

        // Reset during CHECK_PRESS with btnU held; progress is discarded.
        step();
        bus.btnU = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("rstpre%0d_pulse", k), 8'(pulse_vec()), 8'h00);
            check($sformatf("rstpre%0d_lvl", k), 8'(lvl_vec()), 8'h00);
        end
        rst = 1'b1;
        step();
        check("rst_lvl", 8'(lvl_vec()), 8'h00);
        check("rst_pulse", 8'(pulse_vec()), 8'h00);
        check("rst_sw_sync", bus.sw_sync, 8'h00);
        rst = 1'b0;
        bus.sw = 8'hA5;
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("rstpost%0d_pulse", j), 8'(pulse_vec()), (j == 7) ? 8'h01 : 8'h00);
            check($sformatf("rstpost%0d_lvl", j), 8'(lvl_vec()), (j >= 7) ? 8'h01 : 8'h00);
            check($sformatf("rstpost%0d_sw_sync", j), bus.sw_sync, (j >= 2) ? 8'hA5 : 8'h00);
        end
        bus.btnU = 1'b0;
        repeat (10) step();
        check("end_lvl", 8'(lvl_vec()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
